// File: rtl/fpsr_pkg.sv
// fpsr_pkg: shared FPSR state encodings, widths and display codes.
package fpsr_pkg;
  typedef enum logic [1:0] {
    CC_IDLE = 2'b00,
    CC_RUN  = 2'b01,
    CC_QUIZ = 2'b10,
    CC_DONE = 2'b11
  } cc_state_t;
  localparam int MIN_W = 8;
  localparam logic [4:0] SSD_BLANK = 5'b10000;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: free-running divider that pulses wrap on the cycle its count reaches term.
module tick_prescaler (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] term,
  output logic        wrap
);
  logic [31:0] r_cnt;
  // >= so a lowered terminal count wraps immediately instead of running to 2^32
  assign wrap = en && (r_cnt >= term);
  always_ff @(posedge Clk)
    if (!Reset || clr) r_cnt <= '0;
    else if (en) r_cnt <= wrap ? '0 : r_cnt + 32'd1;
endmodule

// File: rtl/class_clock_sched.sv
// class_clock_sched: game-minute clock with quiz scheduling; CLASS_CLOCK_FAST_FWD_EN adds the ff fast-forward input.
module class_clock_sched
  import fpsr_pkg::*;
#(
  parameter int unsigned      TICK_CYCLES        = 100_000_000,
  parameter logic [MIN_W-1:0] END_MIN            = 8'd90,
  parameter logic [MIN_W-1:0] QUIZ_PERIOD        = 8'd16,
  parameter int unsigned      QUIZ_TIMEOUT_TICKS = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             halt,
  input  logic             quiz_ack,
`ifdef CLASS_CLOCK_FAST_FWD_EN
  input  logic             ff,
`endif
  output logic [MIN_W-1:0] minutes,
  output logic             tick,
  output logic             quiz_req,
  output logic             quiz_miss,
  output logic             class_over,
  output logic [1:0]       state
);
  localparam logic [31:0] NORM_TERM = 32'(TICK_CYCLES - 1);
  localparam logic [31:0] FF_TERM = (TICK_CYCLES >> 4) > 2 ? 32'((TICK_CYCLES >> 4) - 1) : 32'd1;
  localparam logic [MIN_W-1:0] QP = QUIZ_PERIOD == 0 ? 8'd1 : QUIZ_PERIOD;
  localparam int QT_W = $clog2(QUIZ_TIMEOUT_TICKS + 1);
  localparam logic [QT_W-1:0] QT_LAST = QT_W'(QUIZ_TIMEOUT_TICKS - 1);
  cc_state_t r_state, w_state;
  logic [MIN_W-1:0] r_minutes, w_minutes, w_min_inc;
  logic [QT_W-1:0] r_qt, w_qt;
  logic r_tick, r_req, r_miss, r_over;
  logic w_tick, w_req, w_miss, w_over, w_clr, w_wrap, w_timeout, w_quiz_hit;
  logic [31:0] w_term;
`ifdef CLASS_CLOCK_FAST_FWD_EN
  assign w_term = (ff && r_state == CC_RUN) ? FF_TERM : NORM_TERM;
`else
  assign w_term = NORM_TERM;
`endif
  tick_prescaler u_presc (
    .Clk   (Clk),
    .Reset (Reset),
    .clr   (w_clr),
    .en    (r_state == CC_RUN || r_state == CC_QUIZ),
    .term  (w_term),
    .wrap  (w_wrap)
  );
  assign w_min_inc  = r_minutes + 8'd1;
  assign w_quiz_hit = QUIZ_PERIOD != 0 && (w_min_inc % QP) == '0;
  assign w_timeout  = w_wrap && r_qt == QT_LAST;
  always_comb begin
    w_state   = r_state;
    w_minutes = r_minutes;
    w_qt      = r_qt;
    w_tick    = 1'b0;
    w_miss    = 1'b0;
    w_req     = r_req;
    w_over    = r_over;
    w_clr     = 1'b0;
    case (r_state)
      CC_IDLE: begin
        w_clr = 1'b1;
        if (start) w_state = CC_RUN;
      end
      CC_RUN: begin
        if (halt) begin
          w_state = CC_DONE;
          w_over  = 1'b1;
        end else if (w_wrap) begin
          w_minutes = w_min_inc;
          w_tick    = 1'b1;
          if (w_min_inc == END_MIN) begin
            w_state = CC_DONE;
            w_over  = 1'b1;
          end else if (w_quiz_hit) begin
            w_state = CC_QUIZ;
            w_req   = 1'b1;
            w_qt    = '0;
          end
        end
      end
      CC_QUIZ: begin
        if (halt) begin
          w_state = CC_DONE;
          w_over  = 1'b1;
          w_req   = 1'b0;
        end else if (quiz_ack || w_timeout) begin
          w_state = CC_RUN;
          w_req   = 1'b0;
          w_miss  = !quiz_ack;
          w_clr   = 1'b1;
        end else if (w_wrap) begin
          w_qt = r_qt + 1'b1;
        end
      end
      default: w_req = 1'b0;
    endcase
  end
  always_ff @(posedge Clk)
    if (!Reset) begin
      r_state   <= CC_IDLE;
      r_minutes <= '0;
      r_qt      <= '0;
      r_tick    <= 1'b0;
      r_req     <= 1'b0;
      r_miss    <= 1'b0;
      r_over    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_minutes <= w_minutes;
      r_qt      <= w_qt;
      r_tick    <= w_tick;
      r_req     <= w_req;
      r_miss    <= w_miss;
      r_over    <= w_over;
    end
  assign minutes    = r_minutes;
  assign tick       = r_tick;
  assign quiz_req   = r_req;
  assign quiz_miss  = r_miss;
  assign class_over = r_over;
  assign state      = r_state;
endmodule

// File: tb/tb_class_clock_sched.sv
// tb_class_clock_sched: directed checks of the game clock, quiz timeout/ack, end of class and halt.
module tb_class_clock_sched;
  logic Clk = 1'b0, Reset = 1'b0, start = 1'b0, halt = 1'b0, quiz_ack = 1'b0, ff = 1'b0;
  logic [7:0] minutes;
  logic tick, quiz_req, quiz_miss, class_over;
  logic [1:0] state;
  int n_chk = 0, n_fail = 0;
  always #5 Clk = ~Clk;
  class_clock_sched #(
    .TICK_CYCLES(4), .END_MIN(8'd10), .QUIZ_PERIOD(8'd3), .QUIZ_TIMEOUT_TICKS(2)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .halt(halt), .quiz_ack(quiz_ack),
`ifdef CLASS_CLOCK_FAST_FWD_EN
    .ff(ff),
`endif
    .minutes(minutes), .tick(tick), .quiz_req(quiz_req), .quiz_miss(quiz_miss),
    .class_over(class_over), .state(state)
  );
`ifdef CLASS_CLOCK_FAST_FWD_EN
  logic [7:0] f_minutes;
  logic f_tick, f_req, f_miss, f_over;
  logic [1:0] f_state;
  class_clock_sched #(
    .TICK_CYCLES(64), .END_MIN(8'd10), .QUIZ_PERIOD(8'd0), .QUIZ_TIMEOUT_TICKS(2)
  ) dut_ff (
    .Clk(Clk), .Reset(Reset), .start(start), .halt(halt), .quiz_ack(quiz_ack), .ff(ff),
    .minutes(f_minutes), .tick(f_tick), .quiz_req(f_req), .quiz_miss(f_miss),
    .class_over(f_over), .state(f_state)
  );
`endif
  task automatic chk(input string tag, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask
  initial begin
    int miss_seen;
    cyc(2);
    chk("rst_state", state, 0);
    chk("rst_min", minutes, 0);
    chk("rst_outs", {tick, quiz_req, quiz_miss, class_over}, 0);
    Reset = 1'b1;
    halt = 1'b1;
    cyc(2);
    chk("idle_halt_ignored", state, 0);
    halt = 1'b0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("start_run", state, 1);
    cyc(3);
    chk("pre_tick1", {tick, minutes}, 0);
    cyc(1);
    chk("tick1", tick, 1);
    chk("min1", minutes, 1);
    cyc(1);
    chk("tick_pulse", tick, 0);
    cyc(3);
    chk("min2", {tick, minutes}, {1'b1, 8'd2});
    cyc(4);
    chk("quiz3_min", minutes, 3);
    chk("quiz3_req", {quiz_req, state}, {1'b1, 2'd2});
    cyc(7);
    chk("quiz3_wait", {quiz_req, quiz_miss, minutes}, {1'b1, 1'b0, 8'd3});
    cyc(1);
    chk("quiz3_miss", {quiz_miss, quiz_req, state}, {1'b1, 1'b0, 2'd1});
    cyc(1);
    chk("miss_pulse", quiz_miss, 0);
    cyc(2);
    chk("after_miss_hold", minutes, 3);
    cyc(1);
    chk("min4", {tick, minutes}, {1'b1, 8'd4});
    cyc(8);
    chk("quiz6", {minutes, state}, {8'd6, 2'd2});
    cyc(7);
    quiz_ack = 1'b1;
    cyc(1);
    quiz_ack = 1'b0;
    chk("ack_vs_timeout", {quiz_miss, quiz_req, state}, {1'b0, 1'b0, 2'd1});
    cyc(8);
    chk("min8", minutes, 8);
    cyc(4);
    chk("quiz9", {minutes, quiz_req, state}, {8'd9, 1'b1, 2'd2});
    quiz_ack = 1'b1;
    cyc(1);
    quiz_ack = 1'b0;
    chk("ack9", {quiz_req, state}, {1'b0, 2'd1});
    cyc(4);
    chk("end_min", minutes, 10);
    chk("end_state", {class_over, state, quiz_req}, {1'b1, 2'd3, 1'b0});
    start = 1'b1;
    quiz_ack = 1'b1;
    cyc(1);
    start = 1'b0;
    quiz_ack = 1'b0;
    cyc(10);
    chk("done_frozen", {minutes, state, class_over, tick}, {8'd10, 2'd3, 1'b1, 1'b0});
    Reset = 1'b0;
    cyc(1);
    chk("rst_mid", {minutes, state, class_over}, 0);
    Reset = 1'b1;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(12);
    chk("halt_setup", {minutes, quiz_req, state}, {8'd3, 1'b1, 2'd2});
    halt = 1'b1;
    miss_seen = 0;
    cyc(1);
    chk("halt_done", {state, quiz_req, quiz_miss, class_over}, {2'd3, 1'b0, 1'b0, 1'b1});
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      miss_seen |= int'(quiz_miss);
    end
    chk("halt_no_miss", miss_seen, 0);
    chk("halt_min", minutes, 3);
    halt = 1'b0;
    Reset = 1'b0;
    cyc(1);
    chk("rst_final", {minutes, tick, quiz_req, quiz_miss, class_over, state}, 0);
`ifdef CLASS_CLOCK_FAST_FWD_EN
    Reset = 1'b1;
    ff = 1'b1;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    chk("ff_pre", f_tick, 0);
    cyc(1);
    chk("ff_tick1", {f_tick, f_minutes}, {1'b1, 8'd1});
    cyc(4);
    chk("ff_tick2", {f_tick, f_minutes}, {1'b1, 8'd2});
    ff = 1'b0;
    cyc(63);
    chk("slow_pre", {f_tick, f_minutes}, {1'b0, 8'd2});
    cyc(1);
    chk("slow_tick", {f_tick, f_minutes}, {1'b1, 8'd3});
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
